// File: rtl/lcd_char_if.sv
// lcd_char_if: bundle between the character-LCD write engine, the mode page
// that supplies characters, and the parallel HD44780 bus.
//
// Handshake: there is no valid/ready pair. The engine owns `index`. The mode
// page answers on `char_in` one clock after `index` changes, with no
// back-pressure. Every LCD transfer is a fixed strobe: RS/DATA set up, E high,
// E low, then a settle wait. RS and DATA are held from setup through the wait.
interface lcd_char_if;
  logic [7:0] char_in;     // ASCII code from the mode page (registered there)
  logic [4:0] index;       // cell select: 0-15 line 1, 16-31 line 2
  logic       lcd_rs;      // 0 = command, 1 = data
  logic       lcd_rw;      // always write
  logic       lcd_e;       // enable strobe
  logic [7:0] lcd_data;    // parallel data bus
  logic       init_done;   // panel initialised, sticky until reset
  logic       frame_done;  // one-cycle pulse at the end of each frame

  // Engine side
  modport master (
    input  char_in,
    output index, lcd_rs, lcd_rw, lcd_e, lcd_data, init_done, frame_done
  );

  // Mode page / panel side
  modport slave (
    output char_in,
    input  index, lcd_rs, lcd_rw, lcd_e, lcd_data, init_done, frame_done
  );
endinterface

// File: rtl/lcd_char_driver.sv
// lcd_char_driver: write engine for a 16x2 HD44780-compatible character LCD.
// After reset it waits for panel power-up, sends the init commands
// (0x38, 0x0C, 0x06, 0x01) and then refreshes all 32 cells forever:
// 0x80, 16 line-1 characters, 0xC0, 16 line-2 characters.
//
// Optional feature macro: LCD_REFRESH_GAP_EN
//   defined   -> after each frame an idle GAP of REFRESH_GAP_CYC cycles
//   undefined -> the next frame's 0x80 command follows frame_done directly
//
// All delays share one 24-bit down-counter; every cycle parameter must be
// below 2^24 and at least 1.
module lcd_char_driver #(
  parameter int INIT_WAIT_CYC   = 750000,
  parameter int SETUP_CYC       = 4,
  parameter int E_PULSE_CYC     = 25,
  parameter int CMD_WAIT_CYC    = 2500,
  parameter int CLEAR_WAIT_CYC  = 100000,
  parameter int REFRESH_GAP_CYC = 500000
) (
  input  logic        clk,
  input  logic        rst,          // asynchronous, active low
  lcd_char_if.master  bus,
  output logic [2:0]  state_dbg_o   // current top-level state
);

  typedef enum logic [2:0] {
    S_PWR_WAIT = 3'd0,
    S_INIT     = 3'd1,
    S_ADDR     = 3'd2,
    S_FETCH    = 3'd3,
    S_WRITE    = 3'd4,
    S_GAP      = 3'd5
  } state_t;

  // Sub-phase of a strobe inside INIT, ADDR and WRITE
  typedef enum logic [1:0] {
    PH_SETUP = 2'd0,
    PH_HIGH  = 2'd1,
    PH_WAIT  = 2'd2
  } phase_t;

  localparam logic [23:0] C_INIT  = 24'(INIT_WAIT_CYC);
  localparam logic [23:0] C_SETUP = 24'(SETUP_CYC);
  localparam logic [23:0] C_PULSE = 24'(E_PULSE_CYC);
  localparam logic [23:0] C_CMD   = 24'(CMD_WAIT_CYC);
  localparam logic [23:0] C_CLEAR = 24'(CLEAR_WAIT_CYC);
  localparam logic [23:0] C_GAP   = 24'(REFRESH_GAP_CYC);
  // One cycle for the mode page's registered read, one margin cycle
  localparam logic [23:0] C_FETCH = 24'd2;

  state_t      state_q;
  phase_t      phase_q;
  logic [23:0] cnt_q;
  logic [1:0]  init_k_q;
  logic [4:0]  index_q;
  logic        lcd_e_q;
  logic        lcd_rs_q;
  logic [7:0]  lcd_data_q;
  logic        init_done_q;
  logic        frame_done_q;

  logic [23:0] cnt_dec_d;
  logic        cnt_done_d;
  logic [23:0] wait_len_d;
  logic [4:0]  index_inc_d;

  // Init command table, in issue order
  function automatic logic [7:0] init_cmd(input logic [1:0] k);
    case (k)
      2'd0:    init_cmd = 8'h38;  // 8-bit bus, 2 lines
      2'd1:    init_cmd = 8'h0C;  // display on, cursor off
      2'd2:    init_cmd = 8'h06;  // increment, no shift
      default: init_cmd = 8'h01;  // clear
    endcase
  endfunction

  // DDRAM set-address command for the start of a line
  function automatic logic [7:0] addr_cmd(input logic line2);
    addr_cmd = line2 ? 8'hC0 : 8'h80;
  endfunction

  // Counter decode and next-index arithmetic shared by all states
  always_comb begin
    cnt_dec_d   = cnt_q - 24'd1;
    cnt_done_d  = (cnt_q <= 24'd1);
    // Only the clear command needs the long settle time
    wait_len_d  = (state_q == S_INIT && init_k_q == 2'd3) ? C_CLEAR : C_CMD;
    index_inc_d = index_q + 5'd1;   // 31 wraps naturally to 0
  end

  // Main sequencer: power-up wait, init, address/fetch/write loop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_PWR_WAIT;
      phase_q      <= PH_SETUP;
      cnt_q        <= C_INIT;
      init_k_q     <= 2'd0;
      index_q      <= 5'd0;
      lcd_e_q      <= 1'b0;
      lcd_rs_q     <= 1'b0;
      lcd_data_q   <= 8'h00;
      init_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        S_PWR_WAIT: begin
          if (cnt_done_d) begin
            state_q    <= S_INIT;
            init_k_q   <= 2'd0;
            phase_q    <= PH_SETUP;
            cnt_q      <= C_SETUP;
            lcd_rs_q   <= 1'b0;
            lcd_data_q <= init_cmd(2'd0);
          end else begin
            cnt_q <= cnt_dec_d;
          end
        end

        S_INIT, S_ADDR, S_WRITE: begin
          if (!cnt_done_d) begin
            cnt_q <= cnt_dec_d;
          end else begin
            case (phase_q)
              PH_SETUP: begin
                phase_q <= PH_HIGH;
                cnt_q   <= C_PULSE;
                lcd_e_q <= 1'b1;
              end
              PH_HIGH: begin
                phase_q <= PH_WAIT;
                cnt_q   <= wait_len_d;
                lcd_e_q <= 1'b0;
              end
              PH_WAIT: begin
                // Settle wait over: RS/DATA may change from here on
                phase_q <= PH_SETUP;
                if (state_q == S_INIT) begin
                  cnt_q <= C_SETUP;
                  if (init_k_q == 2'd3) begin
                    init_done_q <= 1'b1;
                    state_q     <= S_ADDR;
                    lcd_rs_q    <= 1'b0;
                    lcd_data_q  <= addr_cmd(index_q[4]);
                  end else begin
                    init_k_q   <= init_k_q + 2'd1;
                    lcd_data_q <= init_cmd(init_k_q + 2'd1);
                  end
                end else if (state_q == S_ADDR) begin
                  state_q <= S_FETCH;
                  cnt_q   <= C_FETCH;
                end else begin
                  // Character written: advance to the next cell
                  index_q <= index_inc_d;
                  if (index_q == 5'd15) begin
                    state_q    <= S_ADDR;
                    cnt_q      <= C_SETUP;
                    lcd_rs_q   <= 1'b0;
                    lcd_data_q <= addr_cmd(1'b1);
                  end else if (index_q == 5'd31) begin
                    frame_done_q <= 1'b1;
`ifdef LCD_REFRESH_GAP_EN
                    state_q      <= S_GAP;
                    cnt_q        <= C_GAP;
`else
                    state_q      <= S_ADDR;
                    cnt_q        <= C_SETUP;
                    lcd_rs_q     <= 1'b0;
                    lcd_data_q   <= addr_cmd(1'b0);
`endif
                  end else begin
                    state_q <= S_FETCH;
                    cnt_q   <= C_FETCH;
                  end
                end
              end
              default: begin
                phase_q <= PH_SETUP;
                cnt_q   <= C_SETUP;
              end
            endcase
          end
        end

        S_FETCH: begin
          // Second fetch cycle: mode page output is valid, capture it
          if (cnt_done_d) begin
            state_q    <= S_WRITE;
            phase_q    <= PH_SETUP;
            cnt_q      <= C_SETUP;
            lcd_rs_q   <= 1'b1;
            lcd_data_q <= bus.char_in;
          end else begin
            cnt_q <= cnt_dec_d;
          end
        end

        S_GAP: begin
          // Only reachable with the refresh gap enabled; E stays low
          if (cnt_done_d) begin
            state_q    <= S_ADDR;
            phase_q    <= PH_SETUP;
            cnt_q      <= C_SETUP;
            lcd_rs_q   <= 1'b0;
            lcd_data_q <= addr_cmd(1'b0);
          end else begin
            cnt_q <= cnt_dec_d;
          end
        end

        default: begin
          state_q <= S_PWR_WAIT;
          phase_q <= PH_SETUP;
          cnt_q   <= C_INIT;
        end
      endcase
    end
  end

  assign bus.index      = index_q;
  assign bus.lcd_rs     = lcd_rs_q;
  assign bus.lcd_rw     = 1'b0;
  assign bus.lcd_e      = lcd_e_q;
  assign bus.lcd_data   = lcd_data_q;
  assign bus.init_done  = init_done_q;
  assign bus.frame_done = frame_done_q;
  assign state_dbg_o    = state_q;

endmodule

// File: tb/tb_lcd_char_driver.sv
// tb_lcd_char_driver: bench for the character-LCD write engine with a
// 1-cycle registered ROM standing in for the mode page.
module tb_lcd_char_driver;

  localparam int INIT_WAIT_CYC   = 20;
  localparam int SETUP_CYC       = 2;
  localparam int E_PULSE_CYC     = 3;
  localparam int CMD_WAIT_CYC    = 5;
  localparam int CLEAR_WAIT_CYC  = 10;
  localparam int REFRESH_GAP_CYC = 30;
  localparam int FETCH_CYC       = 2;
  localparam int WAIT_LIMIT      = 3000;
`ifdef LCD_REFRESH_GAP_EN
  localparam int GAP_EXP = REFRESH_GAP_CYC;
`else
  localparam int GAP_EXP = 0;
`endif

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         rise;
    int         fall;
    int         width;
  } wr_t;

  typedef struct {
    int         start;
    int         width;
    logic [4:0] idx;
  } fd_t;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  int         cyc = 0;
  logic [2:0] state_dbg;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lcd_char_if u_if ();

  lcd_char_driver #(
    .INIT_WAIT_CYC  (INIT_WAIT_CYC),
    .SETUP_CYC      (SETUP_CYC),
    .E_PULSE_CYC    (E_PULSE_CYC),
    .CMD_WAIT_CYC   (CMD_WAIT_CYC),
    .CLEAR_WAIT_CYC (CLEAR_WAIT_CYC),
    .REFRESH_GAP_CYC(REFRESH_GAP_CYC)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (u_if.master),
    .state_dbg_o(state_dbg)
  );

  // ---------------- mode page model ----------------
  logic [7:0] rom [32];
  string      l1, l2;

  always @(posedge clk) u_if.char_in <= rom[u_if.index];

  // ---------------- scoreboard state ----------------
  logic [8:0] exp_q[$];     // {rs, data}
  wr_t        obs_q[$];
  fd_t        fd_q[$];
  int         n_cmp = 0;
  int         n_err = 0;

  // ---------------- bus monitor ----------------
  logic       prev_e = 1'b0, prev_rs = 1'b0, prev_fd = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic [4:0] prev_idx = 5'd0;
  logic       hist_rs   [SETUP_CYC];
  logic [7:0] hist_data [SETUP_CYC];
  logic [4:0] hist_idx  [SETUP_CYC];
  int         hist_n = 0;
  wr_t        cur;
  fd_t        fd_cur;
  int         fd_run = 0;
  int         bus_viol = 0;
  int         bus_checks = 0;
  int         init_done_cyc = -1;

  always @(negedge clk) begin
    if (!rst) begin
      prev_e        = 1'b0;
      prev_fd       = 1'b0;
      hist_n        = 0;
      fd_run        = 0;
      init_done_cyc = -1;
    end else begin
      bus_checks++;
      if (u_if.lcd_rw !== 1'b0) bus_viol++;
      if (init_done_cyc >= 0 && u_if.init_done !== 1'b1) bus_viol++;
      if (u_if.lcd_e && !prev_e) begin
        cur.rs   = u_if.lcd_rs;
        cur.data = u_if.lcd_data;
        cur.rise = cyc;
        for (int i = 0; i < SETUP_CYC; i++)
          if (i < hist_n && (hist_rs[i] !== u_if.lcd_rs ||
                             hist_data[i] !== u_if.lcd_data ||
                             hist_idx[i] !== u_if.index))
            bus_viol++;
      end else if (u_if.lcd_e && prev_e) begin
        if (u_if.lcd_rs !== prev_rs || u_if.lcd_data !== prev_data ||
            u_if.index !== prev_idx)
          bus_viol++;
      end else if (!u_if.lcd_e && prev_e) begin
        cur.fall  = cyc;
        cur.width = cyc - cur.rise;
        obs_q.push_back(cur);
      end
      if (u_if.frame_done && !prev_fd) begin
        fd_cur.start = cyc;
        fd_cur.idx   = u_if.index;
        fd_run       = 1;
      end else if (u_if.frame_done && prev_fd) begin
        fd_run++;
      end else if (!u_if.frame_done && prev_fd) begin
        fd_cur.width = fd_run;
        fd_q.push_back(fd_cur);
      end
      if (u_if.init_done && init_done_cyc < 0) init_done_cyc = cyc;
      for (int i = SETUP_CYC - 1; i > 0; i--) begin
        hist_rs[i]   = hist_rs[i-1];
        hist_data[i] = hist_data[i-1];
        hist_idx[i]  = hist_idx[i-1];
      end
      hist_rs[0]   = u_if.lcd_rs;
      hist_data[0] = u_if.lcd_data;
      hist_idx[0]  = u_if.index;
      if (hist_n < SETUP_CYC) hist_n++;
      prev_e    = u_if.lcd_e;
      prev_rs   = u_if.lcd_rs;
      prev_data = u_if.lcd_data;
      prev_idx  = u_if.index;
      prev_fd   = u_if.frame_done;
    end
  end

  // ---------------- driver helpers ----------------
  task automatic wait_obs(input int n, output bit ok);
    int k;
    k = 0;
    while (obs_q.size() < n && k < WAIT_LIMIT) begin
      @(negedge clk);
      k++;
    end
    ok = (obs_q.size() >= n);
  endtask

  task automatic push_frame();
    exp_q.push_back({1'b0, 8'h80});
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, rom[i]});
    exp_q.push_back({1'b0, 8'hC0});
    for (int i = 16; i < 32; i++) exp_q.push_back({1'b1, rom[i]});
  endtask

  // ---------------- tests ----------------
  task automatic test_reset(output int r);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    n_cmp++; if (u_if.lcd_e !== 1'b0) begin n_err++; $display("FAIL reset_lcd_e: got %0b want 0", u_if.lcd_e); end
    n_cmp++; if (u_if.lcd_rs !== 1'b0) begin n_err++; $display("FAIL reset_lcd_rs: got %0b want 0", u_if.lcd_rs); end
    n_cmp++; if (u_if.lcd_rw !== 1'b0) begin n_err++; $display("FAIL reset_lcd_rw: got %0b want 0", u_if.lcd_rw); end
    n_cmp++; if (u_if.lcd_data !== 8'h00) begin n_err++; $display("FAIL reset_lcd_data: got %02h want 00", u_if.lcd_data); end
    n_cmp++; if (u_if.index !== 5'd0) begin n_err++; $display("FAIL reset_index: got %0d want 0", u_if.index); end
    n_cmp++; if (u_if.init_done !== 1'b0) begin n_err++; $display("FAIL reset_init_done: got %0b want 0", u_if.init_done); end
    n_cmp++; if (u_if.frame_done !== 1'b0) begin n_err++; $display("FAIL reset_frame_done: got %0b want 0", u_if.frame_done); end
    @(negedge clk);
    #1 rst = 1'b1;
    r = cyc;
  endtask

  task automatic test_init(input int r);
    logic [7:0] cmds [4];
    wr_t        o;
    logic [8:0] e;
    bit         ok;
    int         last_fall, exp_rise, k;
    cmds = '{8'h38, 8'h0C, 8'h06, 8'h01};
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, cmds[i]});
    wait_obs(4, ok);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL init_timeout: got %0d writes want 4 (state %0d)", obs_q.size(), state_dbg);
      exp_q.delete();
      return;
    end
    last_fall = 0;
    for (int i = 0; i < 4; i++) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      exp_rise = r + INIT_WAIT_CYC + SETUP_CYC + i * (SETUP_CYC + E_PULSE_CYC + CMD_WAIT_CYC);
      n_cmp++; if ({o.rs, o.data} !== e) begin n_err++; $display("FAIL init_cmd%0d: got rs=%0b data=%02h want rs=%0b data=%02h", i, o.rs, o.data, e[8], e[7:0]); end
      n_cmp++; if (o.width !== E_PULSE_CYC) begin n_err++; $display("FAIL init_e_width%0d: got %0d want %0d", i, o.width, E_PULSE_CYC); end
      n_cmp++; if (o.rise !== exp_rise) begin n_err++; $display("FAIL init_e_rise%0d: got cycle %0d want %0d", i, o.rise, exp_rise); end
      last_fall = o.fall;
    end
    k = 0;
    while (init_done_cyc < 0 && k < WAIT_LIMIT) begin
      @(negedge clk);
      k++;
    end
    n_cmp++; if (init_done_cyc !== last_fall + CLEAR_WAIT_CYC) begin n_err++; $display("FAIL init_done_time: got cycle %0d want %0d", init_done_cyc, last_fall + CLEAR_WAIT_CYC); end
  endtask

  task automatic test_frame();
    wr_t        o;
    fd_t        f;
    logic [8:0] e;
    bit         ok;
    int         prev_fall, exp_rise, k;
    push_frame();
    wait_obs(34, ok);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL frame1_timeout: got %0d writes want 34 (state %0d)", obs_q.size(), state_dbg);
      exp_q.delete();
      return;
    end
    prev_fall = 0;
    for (int j = 0; j < 34; j++) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      if (j == 0) exp_rise = init_done_cyc + SETUP_CYC;
      else exp_rise = prev_fall + CMD_WAIT_CYC + SETUP_CYC + (e[8] ? FETCH_CYC : 0);
      n_cmp++; if ({o.rs, o.data} !== e) begin n_err++; $display("FAIL frame1_write%0d: got rs=%0b data=%02h want rs=%0b data=%02h", j, o.rs, o.data, e[8], e[7:0]); end
      n_cmp++; if (o.rise !== exp_rise) begin n_err++; $display("FAIL frame1_rise%0d: got cycle %0d want %0d", j, o.rise, exp_rise); end
      prev_fall = o.fall;
    end
    k = 0;
    while (fd_q.size() == 0 && k < WAIT_LIMIT) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (fd_q.size() == 0) begin
      n_err++;
      $display("FAIL frame_done_timeout: got no pulse want 1 (state %0d)", state_dbg);
      return;
    end
    f = fd_q.pop_front();
    n_cmp++; if (f.start !== prev_fall + CMD_WAIT_CYC) begin n_err++; $display("FAIL frame_done_time: got cycle %0d want %0d", f.start, prev_fall + CMD_WAIT_CYC); end
    n_cmp++; if (f.width !== 1) begin n_err++; $display("FAIL frame_done_width: got %0d want 1", f.width); end
    n_cmp++; if (f.idx !== 5'd0) begin n_err++; $display("FAIL frame_done_index: got %0d want 0", f.idx); end
    wait_obs(1, ok);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL frame2_start_timeout: got 0 writes want 1");
      return;
    end
    n_cmp++; if ({obs_q[0].rs, obs_q[0].data} !== {1'b0, 8'h80}) begin n_err++; $display("FAIL frame2_first_cmd: got rs=%0b data=%02h want rs=0 data=80", obs_q[0].rs, obs_q[0].data); end
    n_cmp++; if (obs_q[0].rise !== prev_fall + CMD_WAIT_CYC + GAP_EXP + SETUP_CYC) begin n_err++; $display("FAIL frame2_first_rise: got cycle %0d want %0d", obs_q[0].rise, prev_fall + CMD_WAIT_CYC + GAP_EXP + SETUP_CYC); end
  endtask

  task automatic test_char_hold();
    wr_t        o;
    logic [8:0] e;
    bit         ok, hit;
    int         k;
    push_frame();
    k   = 0;
    hit = 1'b0;
    while (!hit && k < WAIT_LIMIT) begin
      @(negedge clk);
      k++;
      hit = (u_if.index == 5'd22) && u_if.lcd_rs && !u_if.lcd_e && (u_if.lcd_data == rom[22]);
    end
    n_cmp++; if (!hit) begin n_err++; $display("FAIL hold_trigger: got no cell-22 setup want one (state %0d)", state_dbg); end
    rom[22] = 8'hA5;
    wait_obs(34, ok);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL frame2_timeout: got %0d writes want 34", obs_q.size());
      exp_q.delete();
      return;
    end
    for (int j = 0; j < 34; j++) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_cmp++; if ({o.rs, o.data} !== e) begin n_err++; $display("FAIL frame2_write%0d: got rs=%0b data=%02h want rs=%0b data=%02h", j, o.rs, o.data, e[8], e[7:0]); end
    end
    push_frame();
    wait_obs(34, ok);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL frame3_timeout: got %0d writes want 34", obs_q.size());
      exp_q.delete();
      return;
    end
    for (int j = 0; j < 34; j++) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_cmp++; if ({o.rs, o.data} !== e) begin n_err++; $display("FAIL frame3_write%0d: got rs=%0b data=%02h want rs=%0b data=%02h", j, o.rs, o.data, e[8], e[7:0]); end
    end
  endtask

  task automatic test_reset_mid_write();
    bit hit;
    int k, r;
    k   = 0;
    hit = 1'b0;
    while (!hit && k < WAIT_LIMIT) begin
      @(negedge clk);
      k++;
      hit = (u_if.index == 5'd7) && u_if.lcd_e && u_if.lcd_rs;
    end
    n_cmp++; if (!hit) begin n_err++; $display("FAIL midreset_trigger: got no cell-7 strobe want one (state %0d)", state_dbg); end
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (u_if.lcd_e !== 1'b0) begin n_err++; $display("FAIL midreset_lcd_e: got %0b want 0", u_if.lcd_e); end
    n_cmp++; if (u_if.lcd_rs !== 1'b0) begin n_err++; $display("FAIL midreset_lcd_rs: got %0b want 0", u_if.lcd_rs); end
    n_cmp++; if (u_if.lcd_data !== 8'h00) begin n_err++; $display("FAIL midreset_lcd_data: got %02h want 00", u_if.lcd_data); end
    n_cmp++; if (u_if.index !== 5'd0) begin n_err++; $display("FAIL midreset_index: got %0d want 0", u_if.index); end
    n_cmp++; if (u_if.init_done !== 1'b0) begin n_err++; $display("FAIL midreset_init_done: got %0b want 0", u_if.init_done); end
    n_cmp++; if (u_if.frame_done !== 1'b0) begin n_err++; $display("FAIL midreset_frame_done: got %0b want 0", u_if.frame_done); end
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    r = cyc;
    obs_q.delete();
    fd_q.delete();
    exp_q.delete();
    test_init(r);
  endtask

  task automatic test_bus_stability();
    n_cmp++; if (bus_viol !== 0) begin n_err++; $display("FAIL bus_stability: got %0d violations want 0", bus_viol); end
    n_cmp++; if (bus_checks < 1000) begin n_err++; $display("FAIL monitor_activity: got %0d samples want >= 1000", bus_checks); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    int r;
    l1 = "Stop Watch      ";
    l2 = "TIME 01:23:45   ";
    for (int i = 0; i < 16; i++) begin
      rom[i]      = l1[i];
      rom[16 + i] = l2[i];
    end
    test_reset(r);
    test_init(r);
    test_frame();
    test_char_hold();
    test_reset_mid_write();
    test_bus_stability();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion want finish before 2000000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/lcd_char_driver.md
# lcd_char_driver

Character-LCD write engine for the 16x2 HD44780-compatible display. It initialises the panel after reset, then refreshes it continuously. It drives the 5-bit `index` bus into the active mode page, which returns the ASCII code on its registered 8-bit `out`. It sequences each command and character as a timed write strobe on the 8-bit parallel LCD bus.

## Interface
Parameters:
- `INIT_WAIT_CYC`, 750000: power-on wait before the first command (15 ms at 50 MHz).
- `SETUP_CYC`, 4: RS/DATA setup cycles before E rises.
- `E_PULSE_CYC`, 25: E high width in cycles.
- `CMD_WAIT_CYC`, 2500: post-strobe wait for normal commands and characters (50 us).
- `CLEAR_WAIT_CYC`, 100000: post-strobe wait after the clear command 0x01 (2 ms).
- `REFRESH_GAP_CYC`, 500000: idle gap between frames, used only with the macro.

Ports:
- `clk`  in  1: system clock.
- `rst`  in  1: asynchronous, active-low reset.
- `char_in`  in  8: ASCII character from the mode page `out`. Valid 1 cycle after `index` changes.
- `index`  out  5: character cell select, 0–15 for line 1 and 16–31 for line 2.
- `lcd_rs`  out  1: 0 = command, 1 = data.
- `lcd_rw`  out  1: tied to 0 (write only).
- `lcd_e`  out  1: enable strobe.
- `lcd_data`  out  8: LCD data bus.
- `init_done`  out  1: high once the init sequence completes; stays high until reset.
- `frame_done`  out  1: 1-cycle pulse after cell 31's post-strobe wait ends.

## Operation
- All delays come from a single 24-bit down-counter. Every parameter must be < 2^24.
- States: PWR_WAIT → INIT(k) → ADDR → FETCH → WRITE → back to ADDR or FETCH. With the macro, GAP is also used.
- PWR_WAIT: count `INIT_WAIT_CYC` cycles, then go to INIT.
- INIT: issue commands 0x38, 0x0C, 0x06, 0x01 in that order.
  - 0x38 = 8-bit, 2 lines. 0x0C = display on, cursor off. 0x06 = increment, no shift. 0x01 = clear.
  - 0x01 uses `CLEAR_WAIT_CYC`. The others use `CMD_WAIT_CYC`.
  - `init_done` rises in the cycle after the 0x01 wait expires.
- ADDR: issue a command with `lcd_rs`=0.
  - `index`=0 → 0x80 (DDRAM line 1).
  - `index`=16 → 0xC0 (DDRAM line 2).
  - Then go to FETCH.
- FETCH: hold 2 cycles, then latch `char_in` into the data register. This covers the mode page's 1-cycle registered latency plus 1 margin cycle.
- WRITE: `lcd_rs`=1, `lcd_data`=latched char, standard strobe, `CMD_WAIT_CYC` wait. Then advance `index`:
  - 15 → 16, then ADDR (line 2).
  - 31 → 0, then pulse `frame_done`, then ADDR (or GAP with the macro).
  - Otherwise `index`+1, then FETCH.
- Strobe, for every command and character:
  - `SETUP_CYC` cycles with E=0.
  - `E_PULSE_CYC` cycles with E=1.
  - E=0, then the post-strobe wait.
  - `lcd_rs` and `lcd_data` stay stable from the start of setup until the end of the wait.
- `index` changes only at the end of a WRITE wait, never during a strobe.
- Reset values: `lcd_e`=0, `lcd_rs`=0, `lcd_rw`=0, `lcd_data`=0x00, `index`=0, `init_done`=0, `frame_done`=0, state=PWR_WAIT, counter=`INIT_WAIT_CYC`.
- Reset asserted mid-operation drops E immediately (asynchronously) and aborts the write. On release, the full power-on wait and init sequence run again.
- Character content is never filtered. Any 8-bit `char_in` value is written verbatim.

## Timing
- One write occupies `SETUP_CYC` + `E_PULSE_CYC` + wait cycles.
- One character cell costs 2 (FETCH) + `SETUP_CYC` + `E_PULSE_CYC` + `CMD_WAIT_CYC` cycles.
- One frame = 2 address commands + 32 character cells.
- Defaults at 50 MHz: about 1.7 ms per frame, about 600 frames/s without the macro.
- `frame_done` goes high the cycle after cell 31's wait ends, coincident with entry into ADDR or GAP.
- `char_in` is sampled on the 2nd FETCH cycle edge. A change on `char_in` after that edge does not affect the current write.

## Configuration
- `LCD_REFRESH_GAP_EN`
  - Defined: after `frame_done`, enter GAP. E stays 0, `index` stays 0. Count `REFRESH_GAP_CYC` cycles, then go to ADDR. This caps the refresh rate and reduces visible flicker.
  - Undefined: the GAP state and its parameter are unused, and ADDR follows `frame_done` directly.

## Test plan
Bench parameters: `INIT_WAIT_CYC`=20, `SETUP_CYC`=2, `E_PULSE_CYC`=3, `CMD_WAIT_CYC`=5, `CLEAR_WAIT_CYC`=10, `REFRESH_GAP_CYC`=30. The mode page is modelled as a 1-cycle registered ROM.
- Reset release → E stays low for 20 cycles, then 4 E pulses each 3 cycles wide with data 0x38, 0x0C, 0x06, 0x01 and RS=0. `init_done` rises 10 cycles after the last E falls.
- After init, ROM returns "Stop Watch" and "TIME 01:23:45" → the captured stream is 0x80, 16 line-1 chars, 0xC0, 16 line-2 chars. RS=0 only on 0x80/0xC0, and chars match the ROM exactly.
- Monitor the bus throughout → `lcd_data`/`lcd_rs` never change while E=1 or during setup. `index` never changes while E=1.
- Cell 31 write completes → `frame_done` is a single-cycle pulse and `index` wraps to 0. The next command is 0x80: after 0 idle cycles without the macro, after 30 idle cycles with `LCD_REFRESH_GAP_EN`.
- Assert `rst` while E=1 during char cell 7 → E drops in the same cycle and all outputs take their reset values. After release, the 20-cycle wait and the full init repeat.
- ROM changes the value at cell 22 mid-frame, after its FETCH → the old value is written this frame and the new value in the next frame.
